// File: rtl/rysy_pkg.sv
// Shared definitions for the rysy bus memory: FSM state type, default
// geometry/timing constants and byte-lane layout.
package rysy_pkg;

    localparam int unsigned DEFAULT_DEPTH = 1024;
    localparam int unsigned DEFAULT_WAIT  = 1;
    localparam int unsigned LANES         = 4;
    localparam int unsigned LANE_W        = 8;
    localparam int unsigned WORD_W        = LANES * LANE_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_t;

endpackage

// File: rtl/rysy_mem_array.sv
// Word-organised storage with per-byte-lane write enables.
// Writes are synchronous; the read port is combinational on idx.
module rysy_mem_array
    import rysy_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [LANES-1:0]  wen,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Lane-masked write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wen[i]) begin
                mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/rysy_bus_mem.sv
// Simple request/ready memory slave with a configurable number of wait
// states. One access is in flight at a time: IDLE accepts, WAIT stalls for
// WAIT cycles, RESP pulses ready for one cycle (and commits writes).
// Optional feature: define RYSY_MEM_ERR_EN to add the err port and flag
// out-of-range addresses instead of wrapping them.
module rysy_bus_mem
    import rysy_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WAIT  = DEFAULT_WAIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready
`ifdef RYSY_MEM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t             state;
    logic [3:0]         cnt;
    logic               cap_we;
    logic [LANES-1:0]   cap_be;
    logic [IDX_W-1:0]   cap_idx;
    logic [WORD_W-1:0]  cap_wdata;
    logic [WORD_W-1:0]  mem_rdata;
    logic [LANES-1:0]   mem_wen;
    logic               cap_oor;
    logic               oor_in;

`ifdef RYSY_MEM_ERR_EN
    // Any address bit above the array's byte range marks the access invalid.
    assign oor_in = |addr[31:IDX_W+2];
    logic unused_addr;
    assign unused_addr = ^addr[1:0];
`else
    // Upper bits are dropped so out-of-range addresses wrap.
    assign oor_in = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};
`endif

    // Access sequencer: capture on accept, count wait states, pulse ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            ready     <= 1'b0;
            cap_we    <= 1'b0;
            cap_be    <= '0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_oor   <= 1'b0;
`ifdef RYSY_MEM_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    ready <= 1'b0;
`ifdef RYSY_MEM_ERR_EN
                    err   <= 1'b0;
`endif
                    if (req) begin
                        cap_we    <= we;
                        cap_be    <= be;
                        cap_idx   <= addr[IDX_W+1:2];
                        cap_wdata <= wdata;
                        cap_oor   <= oor_in;
                        if (WAIT > 0) begin
                            state <= StWait;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= StResp;
                            ready <= 1'b1;
`ifdef RYSY_MEM_ERR_EN
                            err   <= oor_in;
`endif
                        end
                    end
                end
                StWait: begin
                    if (cnt == 4'd0) begin
                        state <= StResp;
                        ready <= 1'b1;
`ifdef RYSY_MEM_ERR_EN
                        err   <= cap_oor;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StResp: begin
                    state <= StIdle;
                    ready <= 1'b0;
`ifdef RYSY_MEM_ERR_EN
                    err   <= 1'b0;
`endif
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b0;
`ifdef RYSY_MEM_ERR_EN
                    err   <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Write commits on the edge that ends RESP; invalid accesses never write.
    always_comb begin
        mem_wen = '0;
        if (state == StResp && cap_we && !cap_oor) begin
            mem_wen = cap_be;
        end
    end

    // Read data only for valid reads in RESP; zero otherwise.
    always_comb begin
        rdata = '0;
        if (state == StResp && !cap_we && !cap_oor) begin
            rdata = mem_rdata;
        end
    end

    rysy_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .wen   (mem_wen),
        .idx   (cap_idx),
        .wdata (cap_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_rysy_bus_mem.sv
// Directed bench for rysy_bus_mem: three instances cover WAIT=1/DEPTH=16,
// WAIT=0 back-to-back reads, and reset abort with WAIT=3.
module tb_rysy_bus_mem;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [3:0]  be    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  ready;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifndef RYSY_MEM_ERR_EN
    assign err = 3'b000;
`endif

    rysy_bus_mem #(.DEPTH(16), .WAIT(1)) dut_a (
        .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0])
`ifdef RYSY_MEM_ERR_EN
        , .err(err[0])
`endif
    );

    rysy_bus_mem #(.DEPTH(1024), .WAIT(0)) dut_b (
        .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1])
`ifdef RYSY_MEM_ERR_EN
        , .err(err[1])
`endif
    );

    rysy_bus_mem #(.DEPTH(64), .WAIT(3)) dut_c (
        .clk(clk), .rst(rst[2]), .req(req[2]), .we(we[2]), .be(be[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2])
`ifdef RYSY_MEM_ERR_EN
        , .err(err[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One access on instance d; inputs are scrambled right after acceptance
    // so a design that fails to hold its captured fields is exposed.
    task automatic access(input int d, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        #1;
        req[d] = 1'b0; we[d] = ~w; be[d] = ~b; addr[d] = a ^ 32'h4; wdata[d] = ~wd;
        lat = 0;
        rd  = 'x;
        er  = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ready[d]) begin
                lat = k;
                rd  = rdata[d];
                er  = err[d];
                break;
            end
        end
        @(negedge clk);
        check("ready_one_cycle", {31'd0, ready[d]}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    int          pulses;

    initial begin
        rst = 3'b111;
        req = 3'b000;
        we  = 3'b000;
        for (int d = 0; d < 3; d++) begin
            be[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_ready", {31'd0, ready[d]}, 32'd0);
            check("reset_rdata", rdata[d], 32'd0);
            check("reset_err", {31'd0, err[d]}, 32'd0);
        end
        rst = 3'b000;

        // Full write then read, WAIT=1 -> ready 2 cycles after accept.
        access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er);
        check("wr_latency", lat, 2);
        check("wr_rdata_zero", rd, 32'h0);
        access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, er);
        check("rd_latency", lat, 2);
        check("rd_full_word", rd, 32'hDEADBEEF);

        // Partial write with lanes 0 and 2.
        access(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, lat, rd, er);
        access(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, rd, er);
        check("partial_write", rd, 32'hDE22BE44);

        // Empty byte enable completes but changes nothing.
        access(0, 1'b1, 4'b0000, 32'h10, 32'h0, lat, rd, er);
        check("be0_latency", lat, 2);
        access(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, rd, er);
        check("be0_unchanged", rd, 32'hDE22BE44);

        // Low address bits ignored.
        access(0, 1'b1, 4'hF, 32'h10, 32'h0000007F, lat, rd, er);
        access(0, 1'b0, 4'hF, 32'h13, 32'h0, lat, rd, er);
        check("unaligned_read", rd, 32'h0000007F);

        // Out-of-range behaviour on DEPTH=16 (byte range 0x00..0x3F).
        access(0, 1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, lat, rd, er);
        access(0, 1'b1, 4'hF, 32'h40, 32'h12345678, lat, rd, er);
        check("oor_wr_latency", lat, 2);
`ifdef RYSY_MEM_ERR_EN
        check("oor_wr_err", {31'd0, er}, 32'd1);
        access(0, 1'b0, 4'hF, 32'h40, 32'h0, lat, rd, er);
        check("oor_rd_err", {31'd0, er}, 32'd1);
        check("oor_rd_zero", rd, 32'h0);
        access(0, 1'b0, 4'hF, 32'h0, 32'h0, lat, rd, er);
        check("oor_word0_kept", rd, 32'hA5A5A5A5);
        check("inrange_err", {31'd0, er}, 32'd0);
`else
        access(0, 1'b0, 4'hF, 32'h0, 32'h0, lat, rd, er);
        check("oor_wraps_word0", rd, 32'h12345678);
`endif

        // WAIT=0: req held high gives ready every other cycle, four pulses.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h100;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b2b_pattern", {31'd0, ready[1]}, {31'd0, (i % 2 == 0) && (i <= 6)});
            pulses += int'(ready[1]);
            if (i == 6) req[1] = 1'b0;
        end
        check("b2b_pulses", pulses, 4);

        // WAIT=3: reset in the second wait cycle aborts the write.
        access(2, 1'b1, 4'hF, 32'h20, 32'h11111111, lat, rd, er);
        check("w3_latency", lat, 4);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst[2] = 1'b1;
        #1;
        check("abort_ready_low", {31'd0, ready[2]}, 32'd0);
        @(negedge clk);
        rst[2] = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(ready[2]);
        end
        check("abort_no_ready", pulses, 0);
        access(2, 1'b0, 4'hF, 32'h20, 32'h0, lat, rd, er);
        check("abort_latency", lat, 4);
        check("abort_old_value", rd, 32'h11111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rysy_bus_mem.md
RYSY_BUS_MEM -- requirements
Module: rysy_bus_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024: memory size in 32-bit words, a power of two, 16..65536.
REQ-002 The block SHALL have parameter WAIT, default 1: wait states per access, 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port req, input, 1 bit: access request from the core.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have port be, input, 4 bits: byte enables; bit i selects wdata/memory byte [8i+7:8i].
REQ-008 The block SHALL have port addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port wdata, input, 32 bits: write data.
REQ-010 The block SHALL have port rdata, output, 32 bits: read data, valid while ready=1.
REQ-011 The block SHALL have port ready, output, 1 bit: access complete, one-cycle pulse.
REQ-012 The block SHALL have port err, output, 1 bit: out-of-range access flag; the port SHALL be present only with RYSY_MEM_ERR_EN defined.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1 at a clock edge, the block SHALL capture addr, we, be and wdata; the next state SHALL be WAIT if WAIT>0, else RESP.
REQ-015 WAIT SHALL last exactly WAIT cycles, counted by a down-counter loaded with WAIT-1, and SHALL then go to RESP.
REQ-016 In RESP, ready SHALL be 1 for exactly one cycle and the next state SHALL be IDLE; ready is thus high WAIT+1 cycles after the accepting edge.
REQ-017 The word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] SHALL be ignored and no alignment check SHALL be made.
REQ-018 A read SHALL return the full 32-bit word on rdata during RESP, regardless of be.
REQ-019 A write SHALL update only the bytes whose be bit is 1; it SHALL commit on the edge ending RESP; rdata SHALL be 0 for writes.
REQ-020 A write with be=4'b0000 SHALL complete with ready but SHALL leave memory unchanged.
REQ-021 req SHALL be ignored in WAIT and RESP; the earliest next acceptance SHALL be the IDLE cycle after ready, giving a throughput of one access per WAIT+2 cycles.
REQ-022 The captured fields SHALL NOT change during an access, even if inputs change.
REQ-023 Outside RESP, rdata and ready SHALL be 0.

Reset
REQ-024 On rst=1, asynchronously: state SHALL be IDLE, the counter 0, ready 0, rdata 0, err 0, and the captured registers 0.
REQ-025 Reset during WAIT or RESP SHALL abort the access; a pending write SHALL be discarded and no ready SHALL follow.
REQ-026 Memory contents SHALL NOT be reset.

Configuration
REQ-027 When RYSY_MEM_ERR_EN is defined, an access with addr >= 4*DEPTH SHALL complete normally with err=1 together with ready, SHALL suppress any write, and SHALL return rdata=0.
REQ-028 When RYSY_MEM_ERR_EN is undefined, out-of-range addresses SHALL wrap modulo DEPTH words and there SHALL be no err port.

Structure
REQ-029 The state typedef (IDLE/WAIT/RESP), the default DEPTH/WAIT constants and the byte-lane width SHALL live in the shared package rysy_pkg.
REQ-030 Storage SHALL be the sub-module rysy_mem_array: DEPTH x 4 byte lanes, synchronous write with per-lane enable, and combinational read of the captured index.

Verification
REQ-031 WAIT=1: write addr=0x10, wdata=0xDEADBEEF, be=4'hF, then read 0x10 -> ready 2 cycles after each accept; rdata=0xDEADBEEF.
REQ-032 Partial write: be=4'b0101, wdata=0x11223344 to a word holding 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-033 WAIT=0: req held high continuously for 4 reads -> ready on alternate cycles, exactly 4 pulses.
REQ-034 WAIT=3: rst asserted in the second WAIT cycle of a write of 0xCAFEF00D to 0x20 -> no ready; a later read of 0x20 returns the old value.
REQ-035 DEPTH=16 with RYSY_MEM_ERR_EN: write to 0x40 -> err=1 with ready and word 0 unchanged; without the macro, the same write overwrites word 0.
REQ-036 addr=0x13, read after a write to 0x10 of 0x0000007F -> rdata=0x0000007F, since addr[1:0] is ignored.
